// File: rtl/sha_digest_hex_tx_pkg.sv
// Shared definitions for the SHA digest hex line transmitter:
// ASCII constants, the line FSM state type and the nibble-to-ASCII helper.
package sha_tx_pkg;

  localparam logic [7:0] SP = 8'h20;
  localparam logic [7:0] LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    ID,
    SP1,
    LEN,
    SP2,
    DIG,
    NL
  } state_t;

  // Lowercase hex digit for one nibble: 0-9 -> '0'-'9', 10-15 -> 'a'-'f'
  function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
    logic [7:0] hexChar;
    if (n < 4'd10) begin
      hexChar = 8'h30 + {4'h0, n};
    end else begin
      hexChar = 8'h57 + {4'h0, n};
    end
    return hexChar;
  endfunction

endpackage

// File: rtl/sha_digest_hex_tx_if.sv
// Bundles the SHA result pulse bus and the outgoing ASCII byte stream.
// The slave side is the transmitter; the master side drives results and tready.
interface sha_digest_hex_tx_if #(
  parameter int DIGEST_BITS = 160
) ();

  logic                   ivalid;
  logic [31:0]            iid;
  logic [60:0]            ilen;
  logic [DIGEST_BITS-1:0] isha;

  logic                   tvalid;
  logic                   tready;
  logic                   tlast;
  logic [7:0]             tdata;

  modport master (
    output ivalid, iid, ilen, isha, tready,
    input  tvalid, tlast, tdata
  );

  modport slave (
    input  ivalid, iid, ilen, isha, tready,
    output tvalid, tlast, tdata
  );

endinterface

// File: rtl/sha_digest_hex_tx_fifo.sv
// Single-clock record FIFO with a registered, show-ahead read port:
// rd_data always holds the current head one cycle after it is written,
// and advances to the next entry on the cycle after rd_en.
module sha_rec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [WIDTH-1:0] r_rdData;

  logic             w_doWr;
  logic             w_doRd;
  logic [PW-1:0]    w_rdPtrNext;
  logic [PW-1:0]    w_level;

  assign w_level     = r_wrPtr - r_rdPtr;
  assign empty       = (w_level == '0);
  assign full        = (w_level == PW'(DEPTH));
  assign level       = w_level;
  assign w_doRd      = rd_en && !empty;
  assign w_doWr      = wr_en && (!full || w_doRd);
  assign w_rdPtrNext = r_rdPtr + PW'(w_doRd);
  assign rd_data     = r_rdData;

  // Advance the wrapping read/write pointers on accepted accesses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doWr) r_wrPtr <= r_wrPtr + PW'(1);
      r_rdPtr <= w_rdPtrNext;
    end
  end

  // Record storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_doWr) r_mem[r_wrPtr[AW-1:0]] <= wr_data;
  end

  // Preload the next head, forwarding a write that lands in the head slot
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdData <= '0;
    end else if (w_doWr && (r_wrPtr[AW-1:0] == w_rdPtrNext[AW-1:0])) begin
      r_rdData <= wr_data;
    end else begin
      r_rdData <= r_mem[w_rdPtrNext[AW-1:0]];
    end
  end

endmodule

// File: rtl/sha_digest_hex_tx.sv
// Captures SHA core result pulses into a record FIFO and prints each record
// as "iiiiiiii llllllllllllllll dddd...\n" in lowercase ASCII hex on a
// valid/ready byte stream. The line in flight is held in a working register
// so the next record's first character can follow the newline with no bubble;
// the reported level counts that in-flight record until its newline transfers.
module sha_digest_hex_tx #(
  parameter int DIGEST_BITS = 160,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  sha_digest_hex_tx_if.slave          bus,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  import sha_tx_pkg::*;

  localparam int DIG_CHARS = DIGEST_BITS / 4;
  localparam int CNT_W     = ($clog2(DIG_CHARS) > 4) ? $clog2(DIG_CHARS) : 4;
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [31:0]            id;
    logic [60:0]            len;
    logic [DIGEST_BITS-1:0] sha;
  } rec_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [CNT_W-1:0]   r_nibCnt;
  logic [CNT_W-1:0]   w_nextNibCnt;
  rec_t               r_cur;
  logic [7:0]         r_tdata;
  logic               r_tvalid;
  logic               r_tlast;
  logic               r_overflow;

  rec_t               w_wrRec;
  rec_t               w_fifoRd;
  rec_t               w_src;
  logic               w_fifoEmpty;
  logic               w_fifoFull;
  logic [LVL_W-1:0]   w_fifoLevel;
  logic [LVL_W-1:0]   w_level;
  logic               w_adv;
  logic               w_load;
  logic               w_nlDone;
  logic               w_push;
  logic [63:0]        w_len64;
  logic [3:0]         w_nibble;
  logic [7:0]         w_nextData;

  assign w_wrRec  = {bus.iid, bus.ilen, bus.isha};
  assign w_nlDone = (r_state == NL) && r_tvalid && bus.tready;
  assign w_adv    = (r_state == IDLE) ? !w_fifoEmpty : (r_tvalid && bus.tready);
  assign w_load   = w_adv && ((r_state == IDLE) || (r_state == NL)) && !w_fifoEmpty;
  assign w_level  = w_fifoLevel + LVL_W'(r_tvalid);
  assign w_push   = bus.ivalid && !w_fifoFull &&
                    ((w_level < LVL_W'(FIFO_DEPTH)) || w_nlDone);

  assign bus.tdata  = r_tdata;
  assign bus.tvalid = r_tvalid;
  assign bus.tlast  = r_tlast;
  assign overflow   = r_overflow;
  assign level      = w_level;

  sha_rec_fifo #(
    .WIDTH ($bits(rec_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_push),
    .wr_data (w_wrRec),
    .rd_en   (w_load),
    .rd_data (w_fifoRd),
    .empty   (w_fifoEmpty),
    .full    (w_fifoFull),
    .level   (w_fifoLevel)
  );

  // FSM state and field nibble counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_nibCnt <= '0;
    end else begin
      r_state  <= w_nextState;
      r_nibCnt <= w_nextNibCnt;
    end
  end

  // Step through the line fields one character per transfer
  always_comb begin
    w_nextState  = r_state;
    w_nextNibCnt = r_nibCnt;
    if (w_adv) begin
      w_nextNibCnt = '0;
      case (r_state)
        IDLE: w_nextState = ID;
        ID: begin
          if (r_nibCnt == CNT_W'(7)) w_nextState = SP1;
          else                       w_nextNibCnt = r_nibCnt + CNT_W'(1);
        end
        SP1: w_nextState = LEN;
        LEN: begin
          if (r_nibCnt == CNT_W'(15)) w_nextState = SP2;
          else                        w_nextNibCnt = r_nibCnt + CNT_W'(1);
        end
        SP2: w_nextState = DIG;
        DIG: begin
          if (r_nibCnt == CNT_W'(DIG_CHARS - 1)) w_nextState = NL;
          else                                   w_nextNibCnt = r_nibCnt + CNT_W'(1);
        end
        NL:      w_nextState = w_fifoEmpty ? IDLE : ID;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Character for the upcoming state/nibble, taken from the FIFO head on a line start
  always_comb begin
    w_src      = w_load ? w_fifoRd : r_cur;
    w_len64    = {3'b000, w_src.len};
    w_nibble   = '0;
    w_nextData = 8'h00;
    case (w_nextState)
      ID: begin
        w_nibble   = 4'(w_src.id >> (4 * (7 - int'(w_nextNibCnt))));
        w_nextData = nibble_to_hex(w_nibble);
      end
      LEN: begin
        w_nibble   = 4'(w_len64 >> (4 * (15 - int'(w_nextNibCnt))));
        w_nextData = nibble_to_hex(w_nibble);
      end
      DIG: begin
        w_nibble   = 4'(w_src.sha >> (4 * (DIG_CHARS - 1 - int'(w_nextNibCnt))));
        w_nextData = nibble_to_hex(w_nibble);
      end
      SP1, SP2: w_nextData = SP;
      NL:       w_nextData = LF;
      default:  w_nextData = 8'h00;
    endcase
  end

  // Registered byte stream outputs, updated only when the FSM advances
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tdata  <= 8'h00;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else if (w_adv) begin
      r_tdata  <= w_nextData;
      r_tvalid <= (w_nextState != IDLE);
      r_tlast  <= (w_nextState == NL);
    end
  end

  // Working copy of the record currently being printed
  always_ff @(posedge clk) begin
    if (w_load) r_cur <= w_fifoRd;
  end

  // Sticky flag for any result pulse that could not be stored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (bus.ivalid && !w_push) begin
      r_overflow <= 1'b1;
    end
  end

endmodule
